axi_perf_wr_mo: RTL and testbench

AXI4 write traffic generator for memory-bandwidth measurement. Issues `burst_num` INCR bursts of `burst_beats` beats at `base_addr + k*burst_stride`. Decouples the AW and W channels and keeps up to MAX_OUTSTANDING bursts in flight, limited by B responses. Drives each beat with a known incrementing data pattern. Sits between the perf-test controller and an AXI interconnect or memory port, as the multi-outstanding successor of the single-burst writer.

---
 rtl/axi_perf_wr_mo.sv | 180 ++++++++++++++++++
 tb/tb_axi_perf_wr_mo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_perf_wr_mo.sv
// Multi-outstanding AXI4 write traffic generator for bandwidth measurement.
// Define AXI_PERF_WR_MO_STATS_EN to build the err_cnt / cycle_cnt statistics counters.
module axi_perf_wr_mo #(
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]                burst_beats,
    input  logic [AXI_ADDR_WIDTH-1:0] burst_stride,
    input  logic [2:0]                burst_awsize,
    input  logic [15:0]               burst_num,
    output logic [15:0]               err_cnt,
    output logic [31:0]               cycle_cnt,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]                m_axi_bresp
);

    localparam logic [15:0] MAX_OUT = 16'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [AXI_ADDR_WIDTH-1:0] stride_r;
    logic [AXI_ADDR_WIDTH-1:0] addr_acc;
    logic [7:0]                beats_r;
    logic [2:0]                size_r;
    logic [15:0]               num_r;
    logic [15:0]               aw_cnt;
    logic [15:0]               w_cnt;
    logic [15:0]               b_cnt;
    logic [7:0]                beat;
    logic [AXI_DATA_WIDTH-1:0] data_cnt;
    logic [15:0]               outstanding;
    logic                      start_acc;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      b_take;
    logic                      last_w_hs;
    logic                      unused_b;

    function automatic logic [AXI_STRB_WIDTH-1:0] strb_mask(input logic [2:0] size);
        logic [AXI_STRB_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
            if (i < (1 << size)) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign start_acc   = (state == IDLE) && start;
    assign outstanding = aw_cnt - b_cnt;

    // AW and W valids derive from registered counters only, so they stay stable
    // while waiting for ready: aw_cnt/w_cnt move only on handshakes, b_cnt only grows.
    assign m_axi_awvalid = (state == RUN) && (aw_cnt < num_r) && (outstanding < MAX_OUT);
    assign m_axi_awaddr  = addr_acc;
    assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_awlen   = beats_r - 8'd1;
    assign m_axi_awsize  = size_r;
    assign m_axi_awburst = 2'b01;

    assign m_axi_wvalid = (state == RUN) && (w_cnt < aw_cnt);
    assign m_axi_wdata  = data_cnt;
    assign m_axi_wstrb  = strb_mask(size_r);
    assign m_axi_wlast  = (beat == beats_r - 8'd1);

    assign m_axi_bready = 1'b1;

    assign aw_hs     = m_axi_awvalid && m_axi_awready;
    assign w_hs      = m_axi_wvalid && m_axi_wready;
    assign b_take    = m_axi_bvalid && ((state == RUN) || (state == DRAIN));
    assign last_w_hs = w_hs && m_axi_wlast && (w_cnt == num_r - 16'd1);
    assign done      = (state == DONE);
    assign unused_b  = ^{m_axi_bid, m_axi_bresp};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (burst_num == 16'd0) ? DONE : RUN;
            RUN:     if (last_w_hs) state_next = DRAIN;
            DRAIN:   if (b_cnt == num_r) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Run configuration and the address accumulator carry no reset; they are
    // loaded on every accepted start before anything consumes them.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            stride_r <= burst_stride;
            beats_r  <= burst_beats;
            size_r   <= burst_awsize;
            num_r    <= burst_num;
            addr_acc <= base_addr;
        end else if (aw_hs) begin
            addr_acc <= addr_acc + stride_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            aw_cnt   <= '0;
            w_cnt    <= '0;
            b_cnt    <= '0;
            beat     <= '0;
            data_cnt <= '0;
        end else begin
            state <= state_next;
            if (start_acc) begin
                busy     <= 1'b1;
                aw_cnt   <= '0;
                w_cnt    <= '0;
                b_cnt    <= '0;
                beat     <= '0;
                data_cnt <= '0;
            end else begin
                if (state_next == DONE || state_next == IDLE) busy <= 1'b0;
                if (aw_hs) aw_cnt <= aw_cnt + 16'd1;
                if (w_hs) begin
                    data_cnt <= data_cnt + 1'b1;
                    if (m_axi_wlast) begin
                        beat  <= '0;
                        w_cnt <= w_cnt + 16'd1;
                    end else begin
                        beat <= beat + 8'd1;
                    end
                end
                if (b_take) b_cnt <= b_cnt + 16'd1;
            end
        end
    end

`ifdef AXI_PERF_WR_MO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            cycle_cnt <= '0;
        end else if (start_acc) begin
            err_cnt   <= '0;
            cycle_cnt <= '0;
        end else begin
            if (b_take && (m_axi_bresp != 2'b00) && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
            if (busy && (state != DONE) && (cycle_cnt != 32'hFFFF_FFFF))
                cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`else
    assign err_cnt   = '0;
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_perf_wr_mo.sv
// Directed bench for axi_perf_wr_mo: AW/W monitors and a delayed B responder feed
// assertion checks made from a linear sequence of steps.
module tb_axi_perf_wr_mo;

`ifdef AXI_PERF_WR_MO_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [19:0] base_addr;
    logic [7:0]  burst_beats;
    logic [19:0] burst_stride;
    logic [2:0]  burst_awsize;
    logic [15:0] burst_num;
    logic [15:0] err_cnt;
    logic [31:0] cycle_cnt;
    logic        awvalid, awready;
    logic [19:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    always #5 clk = ~clk;

    axi_perf_wr_mo #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .base_addr(base_addr), .burst_beats(burst_beats), .burst_stride(burst_stride),
        .burst_awsize(burst_awsize), .burst_num(burst_num),
        .err_cnt(err_cnt), .cycle_cnt(cycle_cnt),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bid(bid), .m_axi_bresp(bresp)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Monitor state
    logic [19:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [15:0] w_data_q[$];
    logic [1:0]  w_strb_q[$];
    int          last_q[$];
    int          b_due[$];
    int aw_hs_n, w_n, done_cnt, busy_cyc, busy_nd, awv_cyc, wv_cyc;
    bit w_early, aw_unstable, aw_pend;
    logic [19:0] aw_addr_h;
    logic [7:0]  aw_len_h;
    bit b_hold;
    int b_credit, b_idx;
    logic [1:0] resp_tbl[8];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            bvalid  = 1'b0;
            bresp   = 2'b00;
            aw_pend = 1'b0;
        end else begin
            if (busy) busy_cyc++;
            if (busy && !done) busy_nd++;
            if (done) done_cnt++;
            if (awvalid) awv_cyc++;
            if (wvalid) begin
                wv_cyc++;
                if (aw_hs_n == 0) w_early = 1'b1;
            end
            if (aw_pend && (!awvalid || awaddr !== aw_addr_h || awlen !== aw_len_h))
                aw_unstable = 1'b1;
            aw_pend   = awvalid && !awready;
            aw_addr_h = awaddr;
            aw_len_h  = awlen;
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                aw_hs_n++;
            end
            if (wvalid && wready) begin
                w_data_q.push_back(wdata);
                w_strb_q.push_back(wstrb);
                if (wlast) begin
                    last_q.push_back(w_n);
                    b_due.push_back(cyc + 2);
                end
                w_n++;
            end
            bvalid = 1'b0;
            bresp  = 2'b00;
            if (b_due.size() > 0 && b_due[0] <= cyc && (!b_hold || b_credit > 0)) begin
                bvalid = 1'b1;
                bresp  = resp_tbl[b_idx % 8];
                b_idx++;
                void'(b_due.pop_front());
                if (b_hold) b_credit--;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_strb_q.delete();
        last_q.delete(); b_due.delete();
        aw_hs_n = 0; w_n = 0; done_cnt = 0; busy_cyc = 0; busy_nd = 0;
        awv_cyc = 0; wv_cyc = 0; w_early = 0; aw_unstable = 0; aw_pend = 0; b_idx = 0;
    endtask

    task automatic start_run(input logic [19:0] b, input logic [7:0] beats,
                             input logic [19:0] s, input logic [2:0] sz,
                             input logic [15:0] n, input int hold);
        @(posedge clk); #1;
        clear_mon();
        base_addr = b; burst_beats = beats; burst_stride = s;
        burst_awsize = sz; burst_num = n; start = 1'b1;
        repeat (hold) begin @(posedge clk); #1; end
        start = 1'b0;
        base_addr = '1; burst_stride = '1; burst_beats = 8'd7; burst_num = 16'd9;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        logic seen;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        seen = done;
        check(tag, 64'(seen), 64'd1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; awready = 1'b1; wready = 1'b1;
        base_addr = '0; burst_beats = '0; burst_stride = '0; burst_awsize = '0; burst_num = '0;
        bid = '0; b_hold = 1'b0; b_credit = 0;
        for (int i = 0; i < 8; i++) resp_tbl[i] = 2'b00;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("const_awburst", 64'(awburst), 64'd1);
        check("const_bready", 64'(bready), 64'd1);
        rst_n = 1'b1;

        // Three 4-beat bursts, B returned two cycles after each wlast
        start_run(20'h100, 8'd4, 20'h10, 3'd1, 16'd3, 1);
        wait_done("t1_done", 300);
        check("t1_aw_count", 64'(aw_hs_n), 64'd3);
        check("t1_awaddr0", 64'(aw_addr_q[0]), 64'h100);
        check("t1_awaddr1", 64'(aw_addr_q[1]), 64'h110);
        check("t1_awaddr2", 64'(aw_addr_q[2]), 64'h120);
        for (int i = 0; i < 3; i++) check("t1_awlen", 64'(aw_len_q[i]), 64'd3);
        check("t1_awid", 64'(awid), 64'd0);
        check("t1_awsize", 64'(awsize), 64'd1);
        check("t1_beats", 64'(w_n), 64'd12);
        for (int i = 0; i < 12; i++) check("t1_wdata", 64'(w_data_q[i]), 64'(i));
        check("t1_wstrb", 64'(w_strb_q[0]), 64'h3);
        check("t1_last_n", 64'(last_q.size()), 64'd3);
        check("t1_last0", 64'(last_q[0]), 64'd3);
        check("t1_last1", 64'(last_q[1]), 64'd7);
        check("t1_last2", 64'(last_q[2]), 64'd11);
        check("t1_w_early", 64'(w_early), 64'd0);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_err_cnt", 64'(err_cnt), 64'd0);
        check("t1_cycle_cnt", 64'(cycle_cnt), STATS_EN ? 64'(busy_nd) : 64'd0);

        // Outstanding limit: B withheld, then released one at a time; address wraps
        b_hold = 1'b1;
        b_credit = 0;
        start_run(20'hFFFE0, 8'd4, 20'h10, 3'd1, 16'd5, 1);
        repeat (40) begin @(posedge clk); #1; end
        check("t2_aw_held", 64'(aw_hs_n), 64'd2);
        check("t2_awv_cycles", 64'(awv_cyc), 64'd2);
        check("t2_awvalid_now", 64'(awvalid), 64'd0);
        check("t2_beats_held", 64'(w_n), 64'd8);
        b_credit = 1;
        repeat (20) begin @(posedge clk); #1; end
        check("t2_aw_after_one_b", 64'(aw_hs_n), 64'd3);
        check("t2_awaddr2_wrap", 64'(aw_addr_q[2]), 64'h00000);
        b_hold = 1'b0;
        wait_done("t2_done", 300);
        check("t2_aw_total", 64'(aw_hs_n), 64'd5);
        check("t2_awaddr4", 64'(aw_addr_q[4]), 64'h00020);
        check("t2_beats", 64'(w_n), 64'd20);
        check("t2_wdata19", 64'(w_data_q[19]), 64'd19);

        // AW stalled with W ready: no W may lead AW, AW held stable
        awready = 1'b0;
        start_run(20'h2000, 8'd2, 20'h40, 3'd1, 16'd1, 1);
        repeat (5) begin @(posedge clk); #1; end
        check("t3_no_w_while_aw_stalled", 64'(wv_cyc), 64'd0);
        check("t3_awvalid_held", 64'(awvalid), 64'd1);
        check("t3_awaddr_held", 64'(awaddr), 64'h2000);
        check("t3_awlen_held", 64'(awlen), 64'd1);
        awready = 1'b1;
        wait_done("t3_done", 100);
        check("t3_aw_unstable", 64'(aw_unstable), 64'd0);
        check("t3_w_early", 64'(w_early), 64'd0);
        check("t3_beats", 64'(w_n), 64'd2);
        check("t3_last", 64'(last_q[0]), 64'd1);

        // burst_beats 0 means 256 beats
        start_run(20'h300, 8'd0, 20'h0, 3'd0, 16'd1, 1);
        wait_done("t4_done", 400);
        check("t4_awlen", 64'(aw_len_q[0]), 64'd255);
        check("t4_beats", 64'(w_n), 64'd256);
        check("t4_last_n", 64'(last_q.size()), 64'd1);
        check("t4_last_idx", 64'(last_q[0]), 64'd255);
        check("t4_wdata255", 64'(w_data_q[255]), 64'd255);
        check("t4_wstrb", 64'(w_strb_q[0]), 64'h1);

        // Second B carries SLVERR
        resp_tbl[1] = 2'b10;
        start_run(20'h400, 8'd1, 20'h4, 3'd1, 16'd3, 1);
        wait_done("t5_done", 200);
        check("t5_aw_count", 64'(aw_hs_n), 64'd3);
        check("t5_err_cnt", 64'(err_cnt), STATS_EN ? 64'd1 : 64'd0);
        resp_tbl[1] = 2'b00;

        // Zero bursts, with start held into the DONE cycle
        start_run(20'h0, 8'd4, 20'h10, 3'd1, 16'd0, 2);
        repeat (5) begin @(posedge clk); #1; end
        check("t6_done_cnt", 64'(done_cnt), 64'd1);
        check("t6_busy_cycles", 64'(busy_cyc), 64'd1);
        check("t6_awvalid_cycles", 64'(awv_cyc), 64'd0);
        check("t6_wvalid_cycles", 64'(wv_cyc), 64'd0);
        check("t6_cycle_cnt", 64'(cycle_cnt), 64'd0);

        // Asynchronous reset in the middle of a run
        start_run(20'h500, 8'd4, 20'h10, 3'd1, 16'd5, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("t7_busy_pre", 64'(busy), 64'd1);
        check("t7_wvalid_pre", 64'(wvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t7_awvalid_rst", 64'(awvalid), 64'd0);
        check("t7_wvalid_rst", 64'(wvalid), 64'd0);
        check("t7_busy_rst", 64'(busy), 64'd0);
        check("t7_cycle_cnt_rst", 64'(cycle_cnt), 64'd0);
        @(posedge clk); #1;
        b_due.delete();
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("t7_idle_after", 64'(busy | awvalid | wvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
